// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake; iterative signed Booth MUL and non-restoring DIV.
// Define SEQ_ALU_FAST_MUL_EN to compute MUL combinationally with single-cycle latency.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic             inc_pc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000, OP_ST   = 5'b00010, OP_ADD  = 5'b00011, OP_SUB  = 5'b00100,
        OP_SHR  = 5'b00101, OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
        OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100,
        OP_ORI  = 5'b01101, OP_MUL  = 5'b01110, OP_DIV  = 5'b01111, OP_NEG  = 5'b10000,
        OP_NOT  = 5'b10001
    } op_e;

    state_e           r_state, w_state_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH+1:0] r_acc;
    logic [WIDTH-1:0] r_lo, r_opd, r_z_hi, r_z_lo;
    logic             r_q1, r_qneg, r_rneg, r_div_zero;

    logic             w_is_div, w_b_zero, w_last;
    logic [WIDTH-1:0] w_sc_hi, w_sc_lo, w_a_abs, w_b_abs;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH+1:0] w_m, w_b_add, w_b_acc, w_dsh, w_dd, w_dr;
    logic [WIDTH-1:0] w_b_lo, w_dq, w_rem;

    assign w_is_div = !inc_pc && (op == OP_DIV);
    assign w_b_zero = (b == '0);
    assign w_last   = (r_cnt == SHW'(WIDTH - 1));
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_dif    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign w_sh     = b[SHW-1:0];
    assign w_a_abs  = a[WIDTH-1] ? -a : a;
    assign w_b_abs  = b[WIDTH-1] ? -b : b;

`ifdef SEQ_ALU_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] w_prod;
    assign w_prod = $signed(a) * $signed(b);
`else
    logic w_is_mul;
    assign w_is_mul = !inc_pc && (op == OP_MUL);
`endif

    always_comb begin
        w_sc_hi = '0;
        w_sc_lo = w_sum[WIDTH-1:0];
        if (inc_pc) begin
            w_sc_lo = b + WIDTH'(1);
        end else begin
            case (op)
                OP_ADD, OP_ADDI, OP_LD, OP_ST: w_sc_hi = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
                OP_SUB: begin
                    w_sc_lo = w_dif[WIDTH-1:0];
                    w_sc_hi = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
                end
                OP_SHR:          w_sc_lo = a >> w_sh;
                OP_SHL:          w_sc_lo = a << w_sh;
                OP_ROR:          w_sc_lo = WIDTH'({a, a} >> w_sh);
                OP_ROL:          w_sc_lo = WIDTH'(({a, a} << w_sh) >> WIDTH);
                OP_AND, OP_ANDI: w_sc_lo = a & b;
                OP_OR, OP_ORI:   w_sc_lo = a | b;
                OP_NEG:          w_sc_lo = -a;
                OP_NOT:          w_sc_lo = ~a;
`ifdef SEQ_ALU_FAST_MUL_EN
                OP_MUL:          {w_sc_hi, w_sc_lo} = w_prod;
`endif
                // only reaches FIN through this path when the divisor is zero
                OP_DIV: begin
                    w_sc_hi = a;
                    w_sc_lo = '1;
                end
                default: ;
            endcase
        end
    end

    // Booth step; two guard bits keep A exact when the multiplicand is the most negative value
    always_comb begin
        w_m = {{2{r_opd[WIDTH-1]}}, r_opd};
        case ({r_lo[0], r_q1})
            2'b01:   w_b_add = r_acc + w_m;
            2'b10:   w_b_add = r_acc - w_m;
            default: w_b_add = r_acc;
        endcase
        w_b_acc = {w_b_add[WIDTH+1], w_b_add[WIDTH+1:1]};
        w_b_lo  = {w_b_add[0], r_lo[WIDTH-1:1]};
    end

    // Non-restoring step on magnitudes; signs are applied when the result is stored
    always_comb begin
        w_dd  = {2'b00, r_opd};
        w_dsh = {r_acc[WIDTH:0], r_lo[WIDTH-1]};
        w_dr  = r_acc[WIDTH+1] ? (w_dsh + w_dd) : (w_dsh - w_dd);
        w_dq  = {r_lo[WIDTH-2:0], ~w_dr[WIDTH+1]};
        w_rem = w_dr[WIDTH-1:0] + (w_dr[WIDTH+1] ? r_opd : '0);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_div && !w_b_zero) w_state_nxt = S_DIV;
`ifndef SEQ_ALU_FAST_MUL_EN
                    else if (w_is_mul)         w_state_nxt = S_MUL;
`endif
                    else                       w_state_nxt = S_FIN;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_opd      <= '0;
            r_q1       <= 1'b0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_div_zero <= 1'b0;
            r_z_hi     <= '0;
            r_z_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_q1       <= 1'b0;
                        r_div_zero <= w_is_div && w_b_zero;
                        r_qneg     <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_rneg     <= a[WIDTH-1];
                        if (w_is_div) begin
                            r_lo  <= w_a_abs;
                            r_opd <= w_b_abs;
                        end else begin
                            r_lo  <= b;
                            r_opd <= a;
                        end
                        if (w_state_nxt == S_FIN) begin
                            r_z_hi <= w_sc_hi;
                            r_z_lo <= w_sc_lo;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_b_acc;
                    r_lo  <= w_b_lo;
                    r_q1  <= r_lo[0];
                    r_cnt <= r_cnt + SHW'(1);
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_z_hi <= w_b_acc[WIDTH-1:0];
                        r_z_lo <= w_b_lo;
                    end
                end
                S_DIV: begin
                    r_acc <= w_dr;
                    r_lo  <= w_dq;
                    r_cnt <= r_cnt + SHW'(1);
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_z_lo <= r_qneg ? -w_dq : w_dq;
                        r_z_hi <= r_rneg ? -w_rem : w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign z_hi     = r_z_hi;
    assign z_lo     = r_z_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model results, a monitor checks each done pulse.
module tb_seq_alu;

    localparam int unsigned W = 32;

    localparam logic [4:0] OP_LD  = 5'b00000, OP_ST  = 5'b00010, OP_ADD  = 5'b00011, OP_SUB  = 5'b00100,
                           OP_SHR = 5'b00101, OP_SHL = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_AND = 5'b01001, OP_OR  = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100,
                           OP_ORI = 5'b01101, OP_MUL = 5'b01110, OP_DIV  = 5'b01111, OP_NEG  = 5'b10000,
                           OP_NOT = 5'b10001;

    logic         clk = 1'b0;
    logic         clr_n, start, inc_pc;
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] z_hi, z_lo;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op), .inc_pc(inc_pc), .a(a), .b(b),
        .busy(busy), .done(done), .z_hi(z_hi), .z_lo(z_lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           bsy;
        int           t0;
        int           id;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           bcnt = 0;
    int           next_id = 0;
    bit           hold_bad = 0;
    logic [W-1:0] last_hi = '0, last_lo = '0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic ip, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t            e;
        longint          sx, sy, p, q, r;
        longint unsigned u;
        int unsigned     n;
        e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = 1; e.bsy = 0; e.t0 = 0; e.id = 0;
        sx = $signed(x);
        sy = $signed(y);
        n  = y[4:0];
        if (ip) begin
            e.lo = y + 1;
        end else begin
            case (o)
                OP_ADD, OP_ADDI, OP_LD, OP_ST: begin
                    u = 64'(x) + 64'(y);
                    e.lo = u[31:0];
                    e.hi = u[63:32];
                end
                OP_SUB: begin
                    e.lo = x - y;
                    e.hi = (x >= y) ? 1 : 0;
                end
                OP_SHR: e.lo = x >> n;
                OP_SHL: e.lo = x << n;
                OP_ROR: begin
                    e.lo = x;
                    for (int unsigned i = 0; i < n; i++) e.lo = {e.lo[0], e.lo[W-1:1]};
                end
                OP_ROL: begin
                    e.lo = x;
                    for (int unsigned i = 0; i < n; i++) e.lo = {e.lo[W-2:0], e.lo[W-1]};
                end
                OP_AND, OP_ANDI: e.lo = x & y;
                OP_OR, OP_ORI:   e.lo = x | y;
                OP_NEG:          e.lo = 0 - x;
                OP_NOT:          e.lo = ~x;
                OP_MUL: begin
                    p = sx * sy;
                    e.lo = p[31:0];
                    e.hi = p[63:32];
`ifndef SEQ_ALU_FAST_MUL_EN
                    e.lat = 33;
                    e.bsy = 32;
`endif
                end
                OP_DIV: begin
                    if (y == 0) begin
                        e.lo = '1;
                        e.hi = x;
                        e.dz = 1'b1;
                    end else begin
                        q = sx / sy;
                        r = sx % sy;
                        e.lo = q[31:0];
                        e.hi = r[31:0];
                        e.lat = 33;
                        e.bsy = 32;
                    end
                end
                default: e.lo = x + y;
            endcase
        end
        return e;
    endfunction

    // Issue one op; with noise, inputs and start are scrambled while the op runs.
    task automatic issue(input logic [4:0] o, input logic ip, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit noise);
        exp_t e;
        bit   seen;
        @(negedge clk);
        op = o; inc_pc = ip; a = x; b = y; start = 1'b1;
        e = model(o, ip, x, y);
        e.t0 = cyc;
        e.id = next_id++;
        sb.push_back(e);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                start = 1'b0;
                seen = 1;
                break;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                a = $urandom; b = $urandom; op = 5'($urandom); inc_pc = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            start = 1'b0;
            check($sformatf("v%0d.timeout_done", e.id), W'(done), W'(1));
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return '1;
            2:       return '0;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", W'(done), W'(0));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d.z_lo", e.id), z_lo, e.lo);
                    check($sformatf("v%0d.z_hi", e.id), z_hi, e.hi);
                    check($sformatf("v%0d.div_zero", e.id), W'(div_zero), W'(e.dz));
                    check($sformatf("v%0d.latency", e.id), W'(cyc - e.t0), W'(e.lat));
                    check($sformatf("v%0d.busy_cycles", e.id), W'(bcnt), W'(e.bsy));
                    check($sformatf("v%0d.z_held", e.id), W'(hold_bad), W'(0));
                end
                last_hi = z_hi; last_lo = z_lo; bcnt = 0; hold_bad = 0;
            end else if (clr_n === 1'b1 && (z_hi !== last_hi || z_lo !== last_lo)) begin
                hold_bad = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; start = 1'b0; inc_pc = 1'b0; op = OP_ADD; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst.z_lo", z_lo, '0);
        check("rst.z_hi", z_hi, '0);
        check("rst.busy", W'(busy), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.div_zero", W'(div_zero), W'(0));
        @(negedge clk);
        clr_n = 1'b1;

        issue(OP_ADD, 1'b0, 32'd7, 32'd5, 0);
        issue(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        issue(OP_SUB, 1'b0, 32'd3, 32'd5, 0);
        issue(OP_MUL, 1'b0, -32'sd3, 32'd7, 0);
        issue(OP_DIV, 1'b0, -32'sd17, 32'd5, 0);
        issue(OP_DIV, 1'b0, 32'd9, 32'd0, 0);
        issue(OP_MUL, 1'b1, 32'd3, 32'h10, 0);
        issue(OP_ROL, 1'b0, 32'h8000_0001, 32'd4, 0);
        issue(OP_MUL, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        issue(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(5'b11111, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);

        // MUL aborted by reset after an ignored mid-op start; no done may follow
        @(negedge clk);
        op = OP_MUL; inc_pc = 1'b0; a = 32'd1234; b = 32'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort.busy_mid", W'(busy), W'(1));
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        check("abort.z_lo", z_lo, '0);
        check("abort.z_hi", z_hi, '0);
        check("abort.busy", W'(busy), W'(0));
        check("abort.done", W'(done), W'(0));
        check("abort.div_zero", W'(div_zero), W'(0));
        last_hi = '0; last_lo = '0; bcnt = 0;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(OP_ADD, 1'b0, 32'd1, 32'd1, 0);

        for (int i = 0; i < 120; i++) begin
            logic [4:0] o;
            o = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV) : 5'($urandom);
            issue(o, 1'($urandom_range(0, 7) == 0), pick(), pick(), 1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
